alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle command sequencer in front of the team's 16-bit `ALU`. It accepts one command per start/done handshake and decomposes it into single-cycle `ALU` micro-operations, one per clock. Its command set is ADD, SUB, NEG, AND, OR, NOT, ABS and MUL (low 16 bits). It owns its `ALU` instance and sits between the instruction/control logic and the datapath.

## Interface
- `MUL_BITS`, default 16: number of multiplier bits MUL iterates over. Legal range is 1..16; anything else is an elaboration error.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: command request; sampled only while `busy`=0.
- `cmd`  in  3: command code; captured with `start`.
- `opA`  in  16: first operand (M side); captured with `start`.
- `opB`  in  16: second operand; captured with `start`.
- `busy`  out  1: command in progress.
- `done`  out  1: one-cycle pulse; `result` is valid and updated in this cycle.
- `result`  out  16: registered result, held until the next `done`.
- `zer`  out  1: registered; equals `result`==0.
- `neg`  out  1: registered; equals `result[15]`.

## Operation
**ALU opc values used**
- 000: M+N+C
- 010: M+1
- 100: M&N
- 101: M|N
- 110: ~M

**States:** IDLE, STEP1, STEP2, MUL_ADD, MUL_DBL, FIN. Exactly one ALU op is issued per busy cycle. Temp register T; MUL uses acc, mcand and mplier.

**Commands and step sequences**
- 000 ADD: STEP1 computes M=A, N=B, C=0, opc 000.
- 001 SUB: STEP1 computes T=~B (opc 110). STEP2 computes M=A, N=T, C=1, opc 000.
- 010 NEG: STEP1 computes T=~A. STEP2 computes M=T, opc 010.
- 011 AND / 100 OR / 101 NOT: STEP1 only, opc 100 / 101 / 110.
- 110 ABS:
  - A[15]=0: STEP1 computes A+0+0 (opc 000, N=0).
  - A[15]=1: same sequence as NEG.
  - ABS(0x8000)=0x8000 with `neg`=1; no saturation.
- 111 MUL:
  - On entry: acc=0, mcand=A, mplier=B, counter=0.
  - Per iteration: if mplier[0]=1, MUL_ADD computes acc=acc+mcand (opc 000, C=0). MUL_DBL then computes mcand=mcand+mcand (opc 000, M=N=mcand) and sets mplier=mplier>>1, counter+1.
  - Exit to FIN after MUL_BITS iterations.
  - Result is acc mod 2^16.

**Transitions:** The last ALU step writes `result`/`zer`/`neg` and moves to FIN. FIN asserts `done` and returns to IDLE combinationally for handshake purposes (see Timing).

**Arithmetic:** all arithmetic wraps modulo 2^16; no overflow flag.

## Timing
- `start` sampled high with `busy`=0 in cycle 0 gives `busy`=1 in cycles 1..N, where N is the ALU step count.
- In cycle N+1: `done`=1, `busy`=0, and the new `result`/`zer`/`neg` are visible.
- Latency N:
  - ADD, AND, OR, NOT, non-negative ABS: 1.
  - SUB, NEG, negative ABS: 2.
  - MUL: MUL_BITS + popcount(B[MUL_BITS-1:0]).
- Back-to-back: `start` in the `done` cycle is accepted; the next command's first step is in the following cycle.
- `start` while `busy`=1 is ignored, with no queueing. `cmd`, `opA` and `opB` may change freely after capture.
- Reset values: `busy`=0, `done`=0, `result`=0x0000, `zer`=1, `neg`=0, state IDLE.
- `rst_n` low at any edge, including mid-MUL, aborts the command: outputs return to reset values, no `done` is issued for the aborted command, and `start` is ignored while `rst_n`=0.
- `result` is unchanged between `done` pulses; intermediate ALU outputs are never visible on `result`.

## Structure
- Package `alu_seq_pkg` holds:
  - command codes `CMD_ADD`..`CMD_MUL` (3 bits);
  - ALU opc constants `OPC_ADDC`=000, `OPC_INC`=010, `OPC_AND`=100, `OPC_OR`=101, `OPC_NOTM`=110;
  - the state enum.
- Single sub-module: one `ALU` instance, with inN, inM, inC and opc driven from sequencer muxes. The sequencer FSM, T, acc, mcand, mplier and counter all live in `alu_seq`; the sequencer is not split into a separate module.

## Test plan
- ADD 0x7FFF+0x0001 with start in cycle 0: `done` in cycle 2, `result`=0x8000, `neg`=1, `zer`=0.
- SUB 0x0005−0x0007: `done` in cycle 3, `result`=0xFFFE, `neg`=1. Then SUB 0x1234−0x1234: `result`=0x0000, `zer`=1.
- NEG 0x8000 gives 0x8000. ABS 0xFFFB gives 0x0005 with `done` in cycle 3. ABS 0x0005 gives 0x0005 with `done` in cycle 2. NOT 0x00FF gives 0xFF00.
- MUL 0x0003×0x0005 (MUL_BITS=16): `done` in cycle 19, `result`=0x000F. MUL 0x0100×0x0100 gives `result`=0x0000, `zer`=1.
- `start` pulsed while `busy` is ignored, with no second `done`. `start` in the `done` cycle gets a new command accepted, with `busy`=1 in the next cycle.
- `rst_n`=0 in cycle 5 of a MUL: next cycle `busy`=0, `result`=0x0000, `zer`=1, `neg`=0, and no `done` ever follows for that MUL.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer: command codes, ALU opcodes
// and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;
  localparam logic [2:0] CMD_NEG = 3'b010;
  localparam logic [2:0] CMD_AND = 3'b011;
  localparam logic [2:0] CMD_OR  = 3'b100;
  localparam logic [2:0] CMD_NOT = 3'b101;
  localparam logic [2:0] CMD_ABS = 3'b110;
  localparam logic [2:0] CMD_MUL = 3'b111;

  localparam logic [2:0] OPC_ADDC = 3'b000;
  localparam logic [2:0] OPC_INC  = 3'b010;
  localparam logic [2:0] OPC_AND  = 3'b100;
  localparam logic [2:0] OPC_OR   = 3'b101;
  localparam logic [2:0] OPC_NOTM = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP1   = 3'd1,
    S_STEP2   = 3'd2,
    S_MUL_ADD = 3'd3,
    S_MUL_DBL = 3'd4,
    S_FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/alu_seq_alu.sv
// Single-cycle combinational ALU issued one micro-operation per clock by
// the sequencer. Opcodes outside the used set return zero.
module alu_seq_alu
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] in_m,
  input  logic [DATA_W-1:0] in_n,
  input  logic              in_c,
  input  logic [2:0]        opc,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] carry_ext;

  assign carry_ext = {{(DATA_W-1){1'b0}}, in_c};

  always_comb begin
    res = '0;
    case (opc)
      OPC_ADDC: res = in_m + in_n + carry_ext;
      OPC_INC:  res = in_m + {{(DATA_W-1){1'b0}}, 1'b1};
      OPC_AND:  res = in_m & in_n;
      OPC_OR:   res = in_m | in_n;
      OPC_NOTM: res = ~in_m;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer: breaks each accepted command into one ALU
// micro-op per clock and publishes a registered result with a done pulse.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int MUL_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zer,
  output logic        neg
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_BITS);

  if (MUL_BITS < 1 || MUL_BITS > 16) begin : g_bad_mul_bits
    $error("alu_seq: MUL_BITS must be in 1..16");
  end

  state_e            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] t_q, t_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zer_q, zer_d;
  logic              neg_q, neg_d;

  logic [DATA_W-1:0] alu_m, alu_n, alu_out;
  logic              alu_c;
  logic [2:0]        alu_opc;
  logic              wr_res;
  logic [DATA_W-1:0] res_val;

  alu_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .in_m (alu_m),
    .in_n (alu_n),
    .in_c (alu_c),
    .opc  (alu_opc),
    .res  (alu_out)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    a_d      = a_q;
    b_d      = b_q;
    t_d      = t_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    alu_m    = a_q;
    alu_n    = b_q;
    alu_c    = 1'b0;
    alu_opc  = OPC_ADDC;
    wr_res   = 1'b0;
    res_val  = alu_out;

    case (state_q)
      // FIN behaves like IDLE so a start in the done cycle is accepted
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          cmd_d = cmd;
          a_d   = opA;
          b_d   = opB;
          if (cmd == CMD_MUL) begin
            acc_d    = '0;
            mcand_d  = opA;
            mplier_d = opB;
            cnt_d    = '0;
            state_d  = opB[0] ? S_MUL_ADD : S_MUL_DBL;
          end else begin
            state_d = S_STEP1;
          end
        end
      end

      S_STEP1: begin
        case (cmd_q)
          CMD_ADD: wr_res = 1'b1;
          CMD_SUB: begin
            alu_m   = b_q;
            alu_opc = OPC_NOTM;
            t_d     = alu_out;
            state_d = S_STEP2;
          end
          CMD_NEG: begin
            alu_opc = OPC_NOTM;
            t_d     = alu_out;
            state_d = S_STEP2;
          end
          CMD_AND: begin
            alu_opc = OPC_AND;
            wr_res  = 1'b1;
          end
          CMD_OR: begin
            alu_opc = OPC_OR;
            wr_res  = 1'b1;
          end
          CMD_NOT: begin
            alu_opc = OPC_NOTM;
            wr_res  = 1'b1;
          end
          CMD_ABS: begin
            if (a_q[DATA_W-1]) begin
              alu_opc = OPC_NOTM;
              t_d     = alu_out;
              state_d = S_STEP2;
            end else begin
              alu_n  = '0;
              wr_res = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
        if (wr_res) state_d = S_FIN;
      end

      // SUB adds A + ~B + 1; NEG and negative ABS increment ~A
      S_STEP2: begin
        if (cmd_q == CMD_SUB) begin
          alu_n = t_q;
          alu_c = 1'b1;
        end else begin
          alu_m   = t_q;
          alu_opc = OPC_INC;
        end
        wr_res  = 1'b1;
        state_d = S_FIN;
      end

      S_MUL_ADD: begin
        alu_m   = acc_q;
        alu_n   = mcand_q;
        acc_d   = alu_out;
        state_d = S_MUL_DBL;
      end

      S_MUL_DBL: begin
        alu_m    = mcand_q;
        alu_n    = mcand_q;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_d == MUL_LAST) begin
          wr_res  = 1'b1;
          res_val = acc_q;
          state_d = S_FIN;
        end else begin
          state_d = mplier_q[1] ? S_MUL_ADD : S_MUL_DBL;
        end
      end

      default: state_d = S_IDLE;
    endcase

    result_d = wr_res ? res_val : result_q;
    zer_d    = wr_res ? (res_val == '0) : zer_q;
    neg_d    = wr_res ? res_val[DATA_W-1] : neg_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zer_q    <= 1'b1;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zer_q    <= zer_d;
      neg_q    <= neg_d;
    end
  end

  // Operand and scratch registers are only read after being loaded
  always_ff @(posedge clk) begin
    cmd_q    <= cmd_d;
    a_q      <= a_d;
    b_q      <= b_d;
    t_q      <= t_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign busy   = (state_q == S_STEP1) || (state_q == S_STEP2) ||
                  (state_q == S_MUL_ADD) || (state_q == S_MUL_DBL);
  assign done   = (state_q == S_FIN);
  assign result = result_q;
  assign zer    = zer_q;
  assign neg    = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of commands with hand-computed results
// and latencies, plus sequences for busy-start, back-to-back and reset abort.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  cmd;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        zer;
  logic        neg;

  int nvec  = 0;
  int nfail = 0;

  alu_seq #(.MUL_BITS(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmd    (cmd),
    .opA    (op_a),
    .opB    (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zer    (zer),
    .neg    (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after an edge (cycle 0); returns one step into cycle 1
  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    cmd   = c;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
    cmd   = ~c;
    op_a  = ~a;
    op_b  = b ^ 16'h5A5A;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (done) n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    issue(v.c, v.a, v.b);
    chk({v.nm, "_busy"}, busy, 1);
    wait_done(1, cyc);
    chk({v.nm, "_cycle"}, cyc, v.lat + 1);
    chk({v.nm, "_result"}, result, v.r);
    chk({v.nm, "_zer"}, zer, (v.r == 16'h0000));
    chk({v.nm, "_neg"}, neg, v.r[15]);
    chk({v.nm, "_busy_fin"}, busy, 0);
    tick();
    chk({v.nm, "_done_once"}, done, 0);
  endtask

  initial begin
    int cyc;
    int nd;

    vecs[0]  = '{CMD_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1,  "add_7fff"};
    vecs[1]  = '{CMD_SUB, 16'h0005, 16'h0007, 16'hFFFE, 2,  "sub_neg"};
    vecs[2]  = '{CMD_SUB, 16'h1234, 16'h1234, 16'h0000, 2,  "sub_zero"};
    vecs[3]  = '{CMD_NEG, 16'h8000, 16'h0000, 16'h8000, 2,  "neg_8000"};
    vecs[4]  = '{CMD_ABS, 16'hFFFB, 16'h0000, 16'h0005, 2,  "abs_neg"};
    vecs[5]  = '{CMD_ABS, 16'h0005, 16'h0000, 16'h0005, 1,  "abs_pos"};
    vecs[6]  = '{CMD_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1,  "not_00ff"};
    vecs[7]  = '{CMD_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1,  "and"};
    vecs[8]  = '{CMD_OR,  16'hF0F0, 16'h0F01, 16'hFFF1, 1,  "or"};
    vecs[9]  = '{CMD_MUL, 16'h0003, 16'h0005, 16'h000F, 18, "mul_3x5"};
    vecs[10] = '{CMD_MUL, 16'h0100, 16'h0100, 16'h0000, 17, "mul_wrap"};
    vecs[11] = '{CMD_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 32, "mul_ffff"};
    vecs[12] = '{CMD_NEG, 16'h0001, 16'h0000, 16'hFFFF, 2,  "neg_1"};
    vecs[13] = '{CMD_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1,  "add_wrap"};
    vecs[14] = '{CMD_MUL, 16'h1234, 16'h0000, 16'h0000, 16, "mul_by0"};
    vecs[15] = '{CMD_ABS, 16'h8000, 16'h0000, 16'h8000, 2,  "abs_8000"};
    vecs[16] = '{CMD_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 18, "mul_ff"};

    rst_n = 1'b0;
    start = 1'b0;
    cmd   = CMD_ADD;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_zer", zer, 1);
    chk("rst_neg", neg, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // start while busy is ignored; exactly one done for the MUL
    issue(CMD_MUL, 16'h0003, 16'h0005);
    tick();
    start = 1'b1;
    cmd   = CMD_ADD;
    op_a  = 16'h0001;
    op_b  = 16'h0001;
    tick();
    start = 1'b0;
    wait_done(3, cyc);
    chk("busy_start_cycle", cyc, 19);
    chk("busy_start_result", result, 16'h000F);
    count_dones(30, nd);
    chk("busy_start_no_2nd_done", nd, 0);
    chk("busy_start_idle", busy, 0);

    // start in the done cycle is accepted
    issue(CMD_ADD, 16'h0002, 16'h0003);
    wait_done(1, cyc);
    chk("b2b_first_result", result, 16'h0005);
    start = 1'b1;
    cmd   = CMD_NOT;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_hold_result", result, 16'h0005);
    wait_done(1, cyc);
    chk("b2b_cycle", cyc, 2);
    chk("b2b_result", result, 16'hFFFF);
    tick();

    // reset in cycle 5 of a MUL aborts it; start during reset is ignored
    issue(CMD_MUL, 16'h0003, 16'h0005);
    repeat (4) tick();
    rst_n = 1'b0;
    start = 1'b1;
    cmd   = CMD_ADD;
    op_a  = 16'h0001;
    op_b  = 16'h0001;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 16'h0000);
    chk("abort_zer", zer, 1);
    chk("abort_neg", neg, 0);
    start = 1'b0;
    rst_n = 1'b1;
    count_dones(40, nd);
    chk("abort_no_done", nd, 0);
    chk("abort_still_idle", busy, 0);

    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
